// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Brief    : Four-digit multiplexed 7-segment scanner with dead-time, blink,
//             blanking and frame-synchronous double-buffered display data.
//  Revision : 1.0
// ============================================================================
module seg7_scan_ctrl #(
   parameter int DIV         = 50000,
   parameter int GAP         = 500,
   parameter int BLINK_X     = 25,
   parameter bit SEG_ACT_LOW = 1'b0,
   parameter bit EN_ACT_LOW  = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank,
   input  logic [3:0]  blink_en,
   input  logic        load,
   output logic [6:0]  seg,
   output logic        ds_dp,
   output logic [3:0]  ds_en,
   output logic        frame_done
);

   localparam int CW = $clog2(((DIV > GAP) ? DIV : GAP) + 1);
   localparam logic [CW-1:0] c_div_last = CW'(DIV - 1);
   localparam logic [CW-1:0] c_gap_last = CW'(GAP - 1);

   typedef enum logic [0:0] {
      ST_GAP = 1'b0,
      ST_ON  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_idx;
   logic [1:0]        w_idx_nxt;
   logic [CW-1:0]     r_phase;
   logic [CW-1:0]     w_phase_nxt;
   logic              w_frame_last;

   logic [BLINK_X-1:0] r_blink;

   logic [15:0]       r_pend_digits;
   logic [3:0]        r_pend_dp;
   logic [3:0]        r_pend_blank;
   logic [3:0]        r_pend_blink;
   logic [15:0]       r_act_digits;
   logic [3:0]        r_act_dp;
   logic [3:0]        r_act_blank;
   logic [3:0]        r_act_blink;

   logic              w_boundary;
   logic              w_dark;
   logic              w_drive;
   logic [3:0]        w_nibble;
   logic [6:0]        w_hex;

   logic [6:0]        r_seg;
   logic              r_dp;
   logic [3:0]        r_en;
   logic              r_fd;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_GAP;
         r_idx   <= 2'd0;
         r_phase <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_phase <= w_phase_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_phase_nxt  = r_phase + CW'(1);
      w_frame_last = 1'b0;
      case (r_state)
         ST_GAP: begin
            if (r_phase == c_gap_last) begin
               w_state_nxt = ST_ON;
               w_phase_nxt = '0;
            end
         end
         ST_ON: begin
            if (r_phase == c_div_last) begin
               w_state_nxt  = ST_GAP;
               w_idx_nxt    = r_idx + 2'd1;
               w_phase_nxt  = '0;
               w_frame_last = (r_idx == 2'd3);
            end
         end
         default: begin
            w_state_nxt = ST_GAP;
            w_idx_nxt   = 2'd0;
            w_phase_nxt = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------- blink
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink <= '0;
      end else begin
         r_blink <= r_blink + BLINK_X'(1);
      end
   end

   // Active set only moves at the frame boundary so a frame is never torn.
   assign w_boundary = (r_state == ST_GAP) && (r_idx == 2'd0) && (r_phase == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_digits <= 16'h0000;
         r_pend_dp     <= 4'b0000;
         r_pend_blank  <= 4'b1111;
         r_pend_blink  <= 4'b0000;
         r_act_digits  <= 16'h0000;
         r_act_dp      <= 4'b0000;
         r_act_blank   <= 4'b1111;
         r_act_blink   <= 4'b0000;
      end else begin
         if (load) begin
            r_pend_digits <= digits;
            r_pend_dp     <= dp_in;
            r_pend_blank  <= blank;
            r_pend_blink  <= blink_en;
         end
         if (w_boundary) begin
            r_act_digits <= r_pend_digits;
            r_act_dp     <= r_pend_dp;
            r_act_blank  <= r_pend_blank;
            r_act_blink  <= r_pend_blink;
         end
      end
   end

   // ---------------------------------------------------------------- decode
   assign w_dark   = r_act_blank[r_idx] | (r_act_blink[r_idx] & r_blink[BLINK_X-1]);
   assign w_drive  = (r_state == ST_ON) & ~w_dark;
   assign w_nibble = r_act_digits[{r_idx, 2'b00} +: 4];

   always_comb begin
      w_hex = 7'h00;
      case (w_nibble)
         4'h0: w_hex = 7'h3F;
         4'h1: w_hex = 7'h06;
         4'h2: w_hex = 7'h5B;
         4'h3: w_hex = 7'h4F;
         4'h4: w_hex = 7'h66;
         4'h5: w_hex = 7'h6D;
         4'h6: w_hex = 7'h7D;
         4'h7: w_hex = 7'h07;
         4'h8: w_hex = 7'h7F;
         4'h9: w_hex = 7'h6F;
         4'hA: w_hex = 7'h77;
         4'hB: w_hex = 7'h7C;
         4'hC: w_hex = 7'h39;
         4'hD: w_hex = 7'h5E;
         4'hE: w_hex = 7'h79;
         4'hF: w_hex = 7'h71;
         default: w_hex = 7'h00;
      endcase
   end

   // Outputs lag the FSM by one cycle; frame_done tracks the same lag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= 7'h00;
         r_dp  <= 1'b0;
         r_en  <= 4'b0000;
         r_fd  <= 1'b0;
      end else begin
         r_seg <= w_drive ? w_hex : 7'h00;
         r_dp  <= w_drive & r_act_dp[r_idx];
         r_en  <= w_drive ? (4'b0001 << r_idx) : 4'b0000;
         r_fd  <= w_frame_last;
      end
   end

   assign seg        = r_seg ^ {7{SEG_ACT_LOW}};
   assign ds_dp      = r_dp ^ SEG_ACT_LOW;
   assign ds_en      = r_en ^ {4{EN_ACT_LOW}};
   assign frame_done = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Brief    : Self-checking bench for seg7_scan_ctrl against a cycle-count model.
//  Revision : 1.0
// ============================================================================
module tb_seg7_scan_ctrl;

   localparam int P_DIV = 8;
   localparam int P_GAP = 2;
   localparam int P_BX  = 4;
   localparam int SLOT  = P_DIV + P_GAP;
   localparam int FRAME = 4 * SLOT;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic [15:0] digits   = 16'h0;
   logic [3:0]  dp_in    = 4'h0;
   logic [3:0]  blank    = 4'h0;
   logic [3:0]  blink_en = 4'h0;
   logic        load     = 1'b0;
   logic [6:0]  seg;
   logic        ds_dp;
   logic [3:0]  ds_en;
   logic        frame_done;

   seg7_scan_ctrl #(
      .DIV         (P_DIV),
      .GAP         (P_GAP),
      .BLINK_X     (P_BX),
      .SEG_ACT_LOW (1'b0),
      .EN_ACT_LOW  (1'b0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits     (digits),
      .dp_in      (dp_in),
      .blank      (blank),
      .blink_en   (blink_en),
      .load       (load),
      .seg        (seg),
      .ds_dp      (ds_dp),
      .ds_en      (ds_en),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int n_cmp = 0;
   int n_bad = 0;

   // Model: n counts clock edges since reset release; slot/frame position follow from it.
   int          n;
   logic [15:0] pd, ad;
   logic [3:0]  pp, ap, pb, ab, pk, ak;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_en;
   logic        e_fd;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic check_outputs();
      chk("ds_en", 16'(ds_en), 16'(e_en));
      chk("seg", 16'(seg), 16'(e_seg));
      chk("ds_dp", 16'(ds_dp), 16'(e_dp));
      chk("frame_done", 16'(frame_done), 16'(e_fd));
   endtask

   task automatic model_reset();
      n = 0;
      pd = 16'h0; ad = 16'h0;
      pp = 4'h0;  ap = 4'h0;
      pb = 4'hF;  ab = 4'hF;
      pk = 4'h0;  ak = 4'h0;
      e_seg = 7'h0; e_dp = 1'b0; e_en = 4'h0; e_fd = 1'b0;
   endtask

   task automatic step();
      int s, d;
      logic on, boff, dark;
      logic [3:0] nib;
      s    = n % FRAME;
      d    = s / SLOT;
      on   = ((s % SLOT) >= P_GAP);
      boff = ((n / (1 << (P_BX - 1))) % 2) == 1;
      dark = ab[d] | (ak[d] & boff);
      nib  = ad[4*d +: 4];
      if (on && !dark) begin
         e_en  = 4'(1 << d);
         e_seg = hex_tab[nib];
         e_dp  = ap[d];
      end else begin
         e_en  = 4'h0;
         e_seg = 7'h0;
         e_dp  = 1'b0;
      end
      e_fd = (s == FRAME - 1);
      if (s == 0) begin
         ad = pd; ap = pp; ab = pb; ak = pk;
      end
      if (load) begin
         pd = digits; pp = dp_in; pb = blank; pk = blink_en;
      end
      n++;
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic run(input int k);
      repeat (k) step();
   endtask

   task automatic do_load(input logic [15:0] dg, input logic [3:0] dp,
                          input logic [3:0] bl, input logic [3:0] bk);
      digits = dg; dp_in = dp; blank = bl; blink_en = bk; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic rst_hold(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
         check_outputs();
      end
   endtask

   initial begin
      model_reset();
      #1;
      check_outputs();
      rst_hold(3);
      rst_n = 1'b1;

      // Dark until a LOAD is committed, then 0,1,2,3 scan.
      run(FRAME + 5);
      do_load(16'h3210, 4'h0, 4'h0, 4'h0);
      run(2 * FRAME + 7);

      // Mid-frame load only takes effect at the next frame.
      run(15);
      do_load(16'hFEDC, 4'b0101, 4'h0, 4'h0);
      run(2 * FRAME);

      // Load on the boundary cycle itself.
      while ((n % FRAME) != 0) step();
      do_load(16'h5A5A, 4'b1010, 4'h0, 4'h0);
      run(2 * FRAME + 3);

      // Blink on digit 2.
      do_load(16'h9876, 4'h0, 4'h0, 4'b0100);
      run(3 * FRAME);

      // Fully blanked display still produces frame_done.
      do_load(16'h1234, 4'hF, 4'hF, 4'h0);
      run(2 * FRAME + 1);

      repeat (25) begin
         run(int'($urandom_range(0, 60)));
         do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end
      run(2 * FRAME);

      // Asynchronous reset while digit 2 is being driven.
      do_load(16'hABCD, 4'b0100, 4'h0, 4'h0);
      run(2 * FRAME);
      while ((n % FRAME) != 2 * SLOT + P_GAP + 3) step();
      chk("pre_rst_en", 16'(ds_en), 16'h0004);
      chk("pre_rst_seg", 16'(seg), 16'h007C);
      chk("pre_rst_dp", 16'(ds_dp), 16'h0001);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      rst_hold(4);
      rst_n = 1'b1;
      run(2 * FRAME);
      do_load(16'h0F0F, 4'h0, 4'h0, 4'h0);
      run(2 * FRAME);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
